seg_display_driver: RTL
=======================

Name: seg_display_driver

Overview:
- Multi-digit 7-segment driver for the Tetris score, level and line counters. Drives NUM_DIGITS HEX displays on the board.
- Accepts a binary value on a load pulse and shows it in hex or decimal. Decimal conversion is sequential (shift-and-add-3).
- Supports leading-zero blanking and an overflow indication. Outputs are registered and held until the next completed load.

Parameters:
- NUM_DIGITS, 6, number of 7-seg digits driven (1..8).
- BIN_WIDTH, 20, width of the binary input value (4..32).
- BLINK_DIV, 25000000, clock cycles per blink half-period (used only with CORE_SEG_BLINK_EN).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- value  input  BIN_WIDTH  binary value to display; sampled on load.
- load  input  1  single-cycle request to convert and display value.
- dec_mode  input  1  1 = decimal, 0 = hex; sampled on load.
- blank_lz  input  1  1 = blank leading zeros; sampled on load.
- enable  input  1  0 = all segments off.
- blink  input  1  blink request (see Optional Feature).
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when segments update.
- seg  output  7*NUM_DIGITS  active-low segments. Digit i occupies bits [7i+6:7i]; bit0 = a … bit6 = g.

Behaviour:
- Reset (async, resetn=0):
  - State returns to IDLE; all internal registers clear.
  - busy=0, done=0.
  - seg = all ones (every digit blank, 7'h7F).
- FSM states: IDLE, CONVERT, LATCH.
- IDLE:
  - load=1 at a clock edge captures value, dec_mode and blank_lz.
  - Next state is CONVERT if dec_mode=1, otherwise LATCH.
- CONVERT:
  - Runs exactly BIN_WIDTH cycles of double-dabble on an internal BCD register of BCD_DIGITS = BIN_WIDTH/3+1 digits.
  - Per cycle: every BCD digit >=5 gets +3, then the whole register shifts left 1, taking in the binary MSB.
  - A bit counter (clog2(BIN_WIDTH+1) bits) goes to LATCH when it reaches BIN_WIDTH.
- LATCH (one cycle): encodes the digits, writes seg, pulses done, returns to IDLE.
- busy = (state != IDLE).
- load while busy is ignored; no queueing.
- Latency from the load edge to seg/done valid:
  - hex mode: 2 edges;
  - decimal mode: BIN_WIDTH+2 edges.
- Hex mode: digit i = value[4i+3:4i]. Bits beyond BIN_WIDTH read as 0.
- Encoding: standard active-low glyphs 0-F (0=7'b1000000, 1=7'b1111001, …, F=7'b0001110).
- Leading-zero blanking (blank_lz=1): digit i>0 is 7'h7F if it and every higher displayed digit are 0. Digit 0 is always shown.
- Overflow: every digit shows a dash (7'b0111111) when either of these holds:
  - decimal mode and any BCD digit at index >= NUM_DIGITS is nonzero;
  - hex mode and BIN_WIDTH > 4*NUM_DIGITS and value[BIN_WIDTH-1:4*NUM_DIGITS] is nonzero.
  Overflow overrides blanking.
- enable: sampled every cycle. When enable=0, seg goes to all ones at the next edge. The encoded digits are kept internally and reappear one edge after enable returns to 1. done and the FSM are unaffected.
- Reset mid-CONVERT: conversion aborts, and the load is lost.

Optional Feature:
- Macro CORE_SEG_BLINK_EN.
- Defined:
  - A free-running counter of clog2(BLINK_DIV) bits wraps at BLINK_DIV-1 and toggles a phase bit.
  - While blink=1 and phase=1, seg reads all ones. Phase resets to 0.
  - Counter and phase run regardless of blink.
- Undefined:
  - No counter logic; the blink port is present but ignored.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_BLANK=7'h7F, SEG_DASH=7'b0111111;
  - FSM state encoding localparams;
  - BCD_DIGITS formula.
- One sub-module, seg7_encode: combinational 4-bit nibble + blank input to 7-bit active-low glyph. Instantiated NUM_DIGITS times via generate.

Test Plan:
- Reset held, then released with no load → seg=42'h3FF_FFFF_FFFF, busy=0, done=0.
- dec_mode=1, blank_lz=1, value=1234, load → done exactly 22 edges later. seg digits 5..0 = 7F, 7F, 1111001, 0100100, 0110000, 0011001.
- dec_mode=1, value=1000000 → all six digits 7'b0111111. value=999999 → six 7'b0010000 ('9').
- dec_mode=0, blank_lz=0, value=20'hABCDE → done 2 edges after load. Digits 5..0 = '0', A, B, C, D, E; busy high for exactly 1 cycle.
- load pulse during CONVERT with a different value → ignored, original result displayed. resetn low at cycle 10 of CONVERT → seg all ones, no done pulse.
- CORE_SEG_BLINK_EN, BLINK_DIV=4, blink=1 → seg alternates between encoded and all ones every 4 cycles. enable=0 → all ones within 1 edge.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants for the 7-segment display driver: blank/dash
//                glyphs, FSM state encoding and BCD digit-count helper.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_LATCH   = 2'd2;

    // Enough BCD digits to hold any BIN_WIDTH-bit binary value.
    function automatic int bcd_digits(input int bin_width);
        return bin_width / 3 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_encode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_encode
//  Description : Hex nibble to active-low 7-segment glyph (bit0 = a .. bit6 = g)
//                with a blank override.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_encode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'h0:    glyph = 7'b1000000;
                4'h1:    glyph = 7'b1111001;
                4'h2:    glyph = 7'b0100100;
                4'h3:    glyph = 7'b0110000;
                4'h4:    glyph = 7'b0011001;
                4'h5:    glyph = 7'b0010010;
                4'h6:    glyph = 7'b0000010;
                4'h7:    glyph = 7'b1111000;
                4'h8:    glyph = 7'b0000000;
                4'h9:    glyph = 7'b0010000;
                4'hA:    glyph = 7'b0001000;
                4'hB:    glyph = 7'b0000011;
                4'hC:    glyph = 7'b1000110;
                4'hD:    glyph = 7'b0100001;
                4'hE:    glyph = 7'b0000110;
                default: glyph = 7'b0001110;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_driver
//  Description : Multi-digit 7-segment driver, hex or sequential double-dabble
//                decimal, leading-zero blanking and overflow dashes.
//                Optional blink support with macro CORE_SEG_BLINK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_WIDTH  = 20,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [BIN_WIDTH-1:0]    value,
    input  logic                    load,
    input  logic                    dec_mode,
    input  logic                    blank_lz,
    input  logic                    enable,
    input  logic                    blink,
    output logic                    busy,
    output logic                    done,
    output logic [7*NUM_DIGITS-1:0] seg
);

    localparam int c_bcd_digits = bcd_digits(BIN_WIDTH);
    localparam int c_bcd_w      = 4 * c_bcd_digits;
    localparam int c_cnt_w      = $clog2(BIN_WIDTH + 1);
    localparam int c_pad_w      = 4 * NUM_DIGITS + c_bcd_w + BIN_WIDTH;

    logic [1:0]              r_state;
    logic [BIN_WIDTH-1:0]    r_shift;
    logic [c_bcd_w-1:0]      r_bcd;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_dec;
    logic                    r_blz;
    logic                    r_done;
    logic [7*NUM_DIGITS-1:0] r_digits;
    logic [7*NUM_DIGITS-1:0] r_seg;

    logic [c_bcd_w-1:0]      w_bcd_adj;
    logic [c_pad_w-1:0]      w_src;
    logic                    w_ovf;
    logic                    w_run;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [7*NUM_DIGITS-1:0] w_enc;
    logic [7*NUM_DIGITS-1:0] w_glyphs;
    logic [7*NUM_DIGITS-1:0] w_disp;
    logic                    w_blink_off;

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < c_bcd_digits; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5)
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    // Zero-extended digit source: anything above the displayed digits is overflow.
    assign w_src = r_dec ? c_pad_w'(r_bcd) : c_pad_w'(r_shift);
    assign w_ovf = |w_src[c_pad_w-1:4*NUM_DIGITS];

    always_comb begin
        w_run   = 1'b1;
        w_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_run = w_run & (w_src[4*i +: 4] == 4'd0);
            if (i != 0)
                w_blank[i] = r_blz & w_run;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        seg7_encode u_enc (
            .nibble (w_src[4*i +: 4]),
            .blank  (w_blank[i]),
            .glyph  (w_enc[7*i +: 7])
        );
    end

    assign w_glyphs = w_ovf ? {NUM_DIGITS{SEG_DASH}} : w_enc;
    assign w_disp   = (r_state == ST_LATCH) ? w_glyphs : r_digits;

`ifdef CORE_SEG_BLINK_EN
    localparam int c_blink_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_phase;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == c_blink_w'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blink_off = blink & r_phase;
`else
    logic w_unused_blink;
    assign w_unused_blink = blink;
    assign w_blink_off    = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_dec    <= 1'b0;
            r_blz    <= 1'b0;
            r_done   <= 1'b0;
            r_digits <= {NUM_DIGITS{SEG_BLANK}};
            r_seg    <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            r_done <= 1'b0;
            r_seg  <= (enable && !w_blink_off) ? w_disp : {NUM_DIGITS{SEG_BLANK}};
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_shift <= value;
                        r_dec   <= dec_mode;
                        r_blz   <= blank_lz;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= dec_mode ? ST_CONVERT : ST_LATCH;
                    end
                end
                ST_CONVERT: begin
                    // Add-3 correction then shift the binary MSB into the BCD register.
                    r_bcd   <= (w_bcd_adj << 1) | c_bcd_w'(r_shift[BIN_WIDTH-1]);
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_w'(BIN_WIDTH - 1))
                        r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_digits <= w_glyphs;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign seg  = r_seg;

endmodule
`default_nettype wire
